matrix3_window_controller: RTL and testbench

Sequencing controller for the 3-row grayscale line buffer (frame_buffer_matrix3) that feeds the Sobel stage. It accepts grayscale pixels through a valid/ready handshake and generates the buffer write addresses, with row slots rotating modulo 3. Whenever a newly written pixel completes a 3x3 neighbourhood, it issues a read of that window and reports the frame coordinates of the window centre together with a ready strobe. It replaces free-running pixel-clock counters with a single-clock, backpressured scheduler.

---
 rtl/matrix3_window_controller.sv | 141 ++++++++++++++
 tb/tb_matrix3_window_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix3_window_controller.sv
// Write/read scheduler for the 3-row Sobel line buffer: writes each accepted pixel, then spends one
// bubble cycle reading the 3x3 window it completes; O_MATRIX_READY follows the read by P_READ_LATENCY.
module matrix3_window_controller #(
  parameter int P_FRAME_COLUMNS     = 640,
  parameter int P_FRAME_ROWS        = 480,
  parameter int P_BUFFER_ROWS       = 3,
  parameter int P_READ_LATENCY      = 1,
  parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS)
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic                           I_FRAME_START,
  input  logic                           I_PIXEL_VALID,
  output logic                           O_PIXEL_READY,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_BUF_COLUMN,
  output logic [1:0]                     O_BUF_ROW,
  output logic                           O_BUF_WRITE_ENABLE,
  output logic                           O_BUF_READ_ENABLE,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_CENTER_COLUMN,
  output logic [P_FRAME_ROW_BITS-1:0]    O_CENTER_ROW,
  output logic                           O_MATRIX_READY,
  output logic                           O_FRAME_DONE
);
  localparam int CB = P_FRAME_COLUMN_BITS;
  localparam int RB = P_FRAME_ROW_BITS;
  localparam int L  = P_READ_LATENCY;
  localparam logic [CB-1:0] COL_LAST  = CB'(P_FRAME_COLUMNS - 1);
  localparam logic [RB-1:0] ROW_LAST  = RB'(P_FRAME_ROWS - 1);
  localparam logic [1:0]    SLOT_LAST = 2'(P_BUFFER_ROWS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t          state;
  logic [CB-1:0]   col, ccol;
  logic [RB-1:0]   row, crow;
  logic [1:0]      slot, cslot;
  logic            last;
  logic [L-1:0]    pipe_vld;
  logic [CB-1:0]   pipe_col [L];
  logic [RB-1:0]   pipe_row [L];

  logic            accept, win_done, pipe_push, pipe_busy;
  logic [1:0]      slot_inc, slot_dec;

  assign accept    = (state == WRITE) && I_PIXEL_VALID;
  assign win_done  = accept && (col >= CB'(2)) && (row >= RB'(2));
  assign pipe_push = (state == READ) && !I_FRAME_START;
  assign pipe_busy = |pipe_vld;
  assign slot_inc  = (slot == SLOT_LAST) ? 2'd0 : slot + 2'd1;
  // The window centre row was written one row slot earlier than the current one.
  assign slot_dec  = (slot == 2'd0) ? SLOT_LAST : slot - 2'd1;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      slot  <= '0;
      ccol  <= '0;
      crow  <= '0;
      cslot <= '0;
      last  <= 1'b0;
    end else if (I_FRAME_START) begin
      state <= WRITE;
      col   <= '0;
      row   <= '0;
      slot  <= '0;
      last  <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= IDLE;
        WRITE: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col  <= '0;
              row  <= row + 1'b1;
              slot <= slot_inc;
            end else begin
              col <= col + 1'b1;
            end
            if (win_done) begin
              ccol  <= col - 1'b1;
              crow  <= row - 1'b1;
              cslot <= slot_dec;
              last  <= (col == COL_LAST) && (row == ROW_LAST);
              state <= READ;
            end
          end
        end
        READ: state <= last ? DONE : WRITE;
        DONE: if (!pipe_busy) state <= IDLE;
      endcase
    end
  end

  // Centre coordinates only advance alongside a valid token, so the outputs hold between strobes.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      pipe_vld <= '0;
      for (int i = 0; i < L; i++) begin
        pipe_col[i] <= '0;
        pipe_row[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= pipe_push;
      if (pipe_push) begin
        pipe_col[0] <= ccol;
        pipe_row[0] <= crow;
      end
      for (int i = 1; i < L; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1] && !I_FRAME_START) begin
          pipe_col[i] <= pipe_col[i-1];
          pipe_row[i] <= pipe_row[i-1];
        end
      end
      if (I_FRAME_START) pipe_vld <= '0;
    end
  end

  always_comb begin
    O_BUF_COLUMN = '0;
    O_BUF_ROW    = '0;
    if (state == WRITE) begin
      O_BUF_COLUMN = col;
      O_BUF_ROW    = slot;
    end else if (state == READ) begin
      O_BUF_COLUMN = ccol;
      O_BUF_ROW    = cslot;
    end
  end

  assign O_PIXEL_READY      = (state == WRITE);
  assign O_BUF_WRITE_ENABLE = accept;
  assign O_BUF_READ_ENABLE  = (state == READ);
  assign O_MATRIX_READY     = pipe_vld[L-1];
  assign O_CENTER_COLUMN    = pipe_col[L-1];
  assign O_CENTER_ROW       = pipe_row[L-1];
  assign O_FRAME_DONE       = (state == DONE) && !pipe_busy;
endmodule

// File: tb/tb_matrix3_window_controller.sv
// Scoreboard bench: two controllers (read latency 1 and 3) on a 6x5 frame share the same stimulus.
module tb_matrix3_window_controller;
  localparam int C = 6;
  localparam int R = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic pix_valid = 1'b0;
  always #5 clk = ~clk;

  logic       rdy1, we1, re1, mr1, fd1, rdy3, we3, re3, mr3, fd3;
  logic [2:0] bc1, cc1, cr1, bc3, cc3, cr3;
  logic [1:0] br1, br3;

  matrix3_window_controller #(.P_FRAME_COLUMNS(C), .P_FRAME_ROWS(R), .P_READ_LATENCY(1)) dut1 (
    .I_CLK(clk), .I_RESET(rst), .I_FRAME_START(frame_start), .I_PIXEL_VALID(pix_valid),
    .O_PIXEL_READY(rdy1), .O_BUF_COLUMN(bc1), .O_BUF_ROW(br1), .O_BUF_WRITE_ENABLE(we1),
    .O_BUF_READ_ENABLE(re1), .O_CENTER_COLUMN(cc1), .O_CENTER_ROW(cr1),
    .O_MATRIX_READY(mr1), .O_FRAME_DONE(fd1));

  matrix3_window_controller #(.P_FRAME_COLUMNS(C), .P_FRAME_ROWS(R), .P_READ_LATENCY(3)) dut3 (
    .I_CLK(clk), .I_RESET(rst), .I_FRAME_START(frame_start), .I_PIXEL_VALID(pix_valid),
    .O_PIXEL_READY(rdy3), .O_BUF_COLUMN(bc3), .O_BUF_ROW(br3), .O_BUF_WRITE_ENABLE(we3),
    .O_BUF_READ_ENABLE(re3), .O_CENTER_COLUMN(cc3), .O_CENTER_ROW(cr3),
    .O_MATRIX_READY(mr3), .O_FRAME_DONE(fd3));

  int n_checks = 0, n_fail = 0, cyc = 0;
  int wr_cnt = 0, mr1_cnt = 0, mr3_cnt = 0, fd1_cnt = 0, fd3_cnt = 0, last_mr1 = 0, last_mr3 = 0;
  int wq[$], rq[$], cq1[$], cq3[$], dq1[$], dq3[$], rt1[$], rt3[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d, expected nothing", name, act);
  endtask

  always @(posedge clk) cyc++;

  // Monitor for the latency-1 instance: writes, reads, strobes, frame done.
  always @(negedge clk) begin
    if (we1 || re1) chk("we_re_exclusive", int'(we1 && re1), 0);
    if (we1) begin
      wr_cnt++;
      chk("write_while_not_ready", int'(rdy1), 1);
      if (wq.size() == 0) flag("unexpected_write", int'(bc1) * 16 + int'(br1));
      else chk("write_addr", int'(bc1) * 16 + int'(br1), wq.pop_front());
    end
    if (mr1) begin
      mr1_cnt++;
      last_mr1 = cyc;
      if (cq1.size() == 0) flag("unexpected_matrix_l1", int'(cc1) * 256 + int'(cr1));
      else chk("centre_l1", int'(cc1) * 256 + int'(cr1), cq1.pop_front());
      if (rt1.size() == 0) flag("strobe_without_read_l1", cyc);
      else chk("latency_l1", cyc - rt1.pop_front(), 1);
    end
    if (re1) begin
      rt1.push_back(cyc);
      if (rq.size() == 0) flag("unexpected_read", int'(bc1) * 16 + int'(br1));
      else chk("read_addr", int'(bc1) * 16 + int'(br1), rq.pop_front());
    end
    if (fd1) begin
      fd1_cnt++;
      if (dq1.size() == 0) flag("unexpected_done_l1", cyc);
      else begin
        void'(dq1.pop_front());
        chk("done_after_strobe_l1", cyc - last_mr1, 1);
      end
    end
    if (frame_start || rst) rt1.delete();
  end

  // Monitor for the latency-3 instance.
  always @(negedge clk) begin
    if (we3 || re3) chk("we_re_exclusive_l3", int'(we3 && re3), 0);
    if (mr3) begin
      mr3_cnt++;
      last_mr3 = cyc;
      if (cq3.size() == 0) flag("unexpected_matrix_l3", int'(cc3) * 256 + int'(cr3));
      else chk("centre_l3", int'(cc3) * 256 + int'(cr3), cq3.pop_front());
      if (rt3.size() == 0) flag("strobe_without_read_l3", cyc);
      else chk("latency_l3", cyc - rt3.pop_front(), 3);
    end
    if (re3) rt3.push_back(cyc);
    if (fd3) begin
      fd3_cnt++;
      if (dq3.size() == 0) flag("unexpected_done_l3", cyc);
      else begin
        void'(dq3.pop_front());
        chk("done_after_strobe_l3", int'(cyc > last_mr3), 1);
      end
    end
    if (frame_start || rst) rt3.delete();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    pix_valid = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Push the expected response for pixel (c,r), then hold it until accepted.
  task automatic send_pixel(input int c, input int r, input bit with_start);
    bit acc;
    int n;
    wq.push_back(c * 16 + r % 3);
    if (c >= 2 && r >= 2) begin
      rq.push_back((c - 1) * 16 + (r + 2) % 3);
      cq1.push_back((c - 1) * 256 + (r - 1));
      cq3.push_back((c - 1) * 256 + (r - 1));
    end
    if (c == C - 1 && r == R - 1) begin
      dq1.push_back(1);
      dq3.push_back(1);
    end
    pix_valid = 1'b1;
    n = 0;
    do begin
      acc = rdy1;
      frame_start = with_start && acc;
      step();
      frame_start = 1'b0;
      n++;
    end while (!acc && n <= 20);
    if (!acc) flag("accept_timeout", n);
  endtask

  task automatic check_drained(input string name);
    chk(name, wq.size() + rq.size() + cq1.size() + cq3.size() + dq1.size() + dq3.size(), 0);
  endtask

  task automatic run_frame(input bit pulse, input bit gaps);
    int w0, m1, m3, d1, d3;
    w0 = wr_cnt; m1 = mr1_cnt; m3 = mr3_cnt; d1 = fd1_cnt; d3 = fd3_cnt;
    if (pulse) pulse_start();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        if (gaps && $urandom_range(0, 1) == 1) begin
          pix_valid = 1'b0;
          repeat ($urandom_range(1, 2)) step();
        end
        send_pixel(c, r, 1'b0);
      end
    pix_valid = 1'b0;
    repeat (12) step();
    chk("frame_writes", wr_cnt - w0, 30);
    chk("frame_windows_l1", mr1_cnt - m1, 12);
    chk("frame_windows_l3", mr3_cnt - m3, 12);
    chk("frame_done_l1", fd1_cnt - d1, 1);
    chk("frame_done_l3", fd3_cnt - d3, 1);
    check_drained("frame_drained");
  endtask

  task automatic check_zero(input string name);
    chk({name, "_l1"}, int'({rdy1, we1, re1, mr1, fd1, bc1, br1, cc1, cr1}), 0);
    chk({name, "_l3"}, int'({rdy3, we3, re3, mr3, fd3, bc3, br3, cc3, cr3}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int m1, m3, d1;
    rst = 1'b1;
    repeat (3) step();
    check_zero("reset_state");
    rst = 1'b0;
    step();
    check_zero("idle_state");

    run_frame(1'b1, 1'b0);
    run_frame(1'b1, 1'b1);

    // Abort: the 20th pixel arrives together with a new frame start.
    d1 = fd1_cnt;
    pulse_start();
    for (int i = 0; i < 19; i++) send_pixel(i % C, i / C, 1'b0);
    send_pixel(19 % C, 19 / C, 1'b1);
    chk("abort_l1_already_emitted", cq1.size(), 0);
    cq3.delete();
    run_frame(1'b0, 1'b0);
    chk("abort_no_extra_done", fd1_cnt - d1, 1);

    // Reset lands on the read cycle of window (1,1).
    pulse_start();
    for (int i = 0; i < 15; i++) send_pixel(i % C, i / C, 1'b0);
    rst = 1'b1;
    pix_valid = 1'b0;
    step();
    rst = 1'b0;
    check_zero("after_reset");
    cq1.delete();
    cq3.delete();
    m1 = mr1_cnt; m3 = mr3_cnt;
    pix_valid = 1'b1;
    repeat (8) step();
    pix_valid = 1'b0;
    chk("no_strobe_after_reset", (mr1_cnt - m1) + (mr3_cnt - m3), 0);
    check_drained("reset_drained");

    run_frame(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
